inbuf_wr_packer: RTL and testbench
==================================

// Module: inbuf_wr_packer
//
// PURPOSE
//   Upstream feeder of the input buffer.
//   Packs narrow host beats (HOST_DATA_W) into full INBUF_DATA_W lines.
//   Writes each line into the input-buffer SRAM FIFO through inbuf_wr_req/inbuf_wr_data.
//   Honours FIFO full back-pressure and zero-pads a partial line on host_in_last.
//
// PARAMETERS
//   HOST_DATA_W   64    width of one host beat
//   INBUF_DATA_W  512   input-buffer line width; must be an integer multiple of HOST_DATA_W
//   CNT_W         16    width of the lines-written counter
//   (local) BEATS = INBUF_DATA_W/HOST_DATA_W; BCNT_W = max(1,$clog2(BEATS))
//
// PORTS
//   clk            in   1             system clock
//   rst_n          in   1             synchronous active-low reset
//   host_in_val    in   1             host beat valid
//   host_in_data   in   HOST_DATA_W   host beat payload
//   host_in_last   in   1             beat closes the current block; line is padded and written
//   host_in_rdy    out  1             packer accepts a beat this cycle
//   inbuf_full     in   1             input-buffer FIFO full
//   inbuf_wr_req   out  1             one-cycle write strobe to the input buffer
//   inbuf_wr_data  out  INBUF_DATA_W  line written when inbuf_wr_req=1
//   pkr_busy       out  1             partial or pending line held
//   pkr_lines_cnt  out  CNT_W         lines written since reset, wraps 2^CNT_W-1 -> 0
//
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//     - state=FILL, beat_cnt=0, line_reg=0, pkr_lines_cnt=0.
//     - Any partial or pending line is discarded.
//   Reset output values: host_in_rdy=1 (combinational from state FILL), inbuf_wr_req=0,
//     inbuf_wr_data=0, pkr_busy=0.
//   Beat handshake: a beat is accepted on any edge where host_in_val & host_in_rdy.
//   FILL (host_in_rdy=1):
//     - An accepted beat is written into line_reg[beat_cnt*HOST_DATA_W +: HOST_DATA_W].
//       Beat 0 occupies the LSBs.
//     - If beat_cnt==BEATS-1 or host_in_last=1: go to PEND and hold beat_cnt.
//     - Otherwise beat_cnt += 1.
//     - Slots not written since the last clear stay 0 (zero padding).
//   PEND (host_in_rdy=0):
//     - inbuf_wr_req = !inbuf_full, combinational.
//     - inbuf_wr_data = line_reg at all times.
//     - On a write cycle, at the next edge: line_reg=0, beat_cnt=0, pkr_lines_cnt+=1, state=FILL.
//     - While inbuf_full=1: stay in PEND, line_reg stable, no request.
//   pkr_busy = (state==PEND) | (beat_cnt!=0).
//   Latency: the last beat accepted at edge N gives inbuf_wr_req=1 in cycle N+1,
//     provided inbuf_full=0.
//   Throughput: BEATS+1 cycles per full line when there is no back-pressure.
//   Boundary cases:
//     - host_in_last on beat BEATS-1 produces exactly one line, no extra pad line.
//     - host_in_last on beat 0 produces a line with BEATS-1 zero slots.
//     - host_in_val is ignored while host_in_rdy=0.
//     - inbuf_full rising in the same cycle the line completes: the request waits,
//       data is unchanged.
//     - BEATS==1: every accepted beat goes straight to PEND.
//
// TESTING
//   1. Reset, then 8 beats 0x0..0x7 back-to-back, inbuf_full=0
//      -> one inbuf_wr_req; data beat k = k in slot k; pkr_lines_cnt=1; host_in_rdy low 1 cycle.
//   2. 3 beats 0xA,0xB,0xC, last on 3rd
//      -> line = {320'b0,0xC,0xB,0xA} in slots 0..2; then beat_cnt=0, pkr_busy=0.
//   3. Full line pending with inbuf_full=1 for 5 cycles
//      -> no inbuf_wr_req, host_in_rdy=0, data stable; write issued on the cycle inbuf_full drops.
//   4. host_in_last on the 8th beat
//      -> exactly one write; pkr_lines_cnt increments by 1.
//   5. rst_n=0 after 4 beats, then 8 new beats
//      -> the first write holds only the new beats; pkr_lines_cnt=1.
//   6. 2^CNT_W lines written
//      -> pkr_lines_cnt wraps to 0.

Source files
------------

// File: rtl/inbuf_wr_packer.sv
// -----------------------------------------------------------------------------
// inbuf_wr_packer
//
// Upstream feeder of the input buffer. Narrow host beats are packed into one
// full input-buffer line, and each completed line is written into the
// input-buffer SRAM FIFO. A beat flagged host_in_last closes the line early.
// Slots that were not written stay zero, so a partial line is zero-padded.
// FIFO full back-pressure holds a completed line until the FIFO can take it.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   host_in_val    host beat valid
//   host_in_data   host beat payload (HOST_DATA_W)
//   host_in_last   beat closes the current block; line is padded and written
//   host_in_rdy    packer accepts a beat this cycle (FILL state)
//   inbuf_full     input-buffer FIFO full
//   inbuf_wr_req   one-cycle write strobe to the input buffer
//   inbuf_wr_data  line presented to the input buffer (INBUF_DATA_W)
//   pkr_busy       a partial or pending line is held
//   pkr_lines_cnt  lines written since reset, wraps to 0
// -----------------------------------------------------------------------------
module inbuf_wr_packer #(
    parameter int HOST_DATA_W  = 64,
    parameter int INBUF_DATA_W = 512,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_in_val,
    input  logic [HOST_DATA_W-1:0]  host_in_data,
    input  logic                    host_in_last,
    output logic                    host_in_rdy,
    input  logic                    inbuf_full,
    output logic                    inbuf_wr_req,
    output logic [INBUF_DATA_W-1:0] inbuf_wr_data,
    output logic                    pkr_busy,
    output logic [CNT_W-1:0]        pkr_lines_cnt
);

    localparam int BEATS  = INBUF_DATA_W / HOST_DATA_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e                  state_q;
    logic [BCNT_W-1:0]       beat_cnt_q;
    logic [INBUF_DATA_W-1:0] line_q;
    logic [CNT_W-1:0]        lines_cnt_q;

    logic                    in_fill_s;
    logic                    in_pend_s;
    logic                    last_slot_s;
    logic                    wr_fire_s;

    // Decode state and the write condition shared by the outputs and the FSM.
    always_comb begin
        in_fill_s   = 1'b0;
        in_pend_s   = 1'b0;
        last_slot_s = 1'b0;
        wr_fire_s   = 1'b0;
        if (state_q == ST_FILL) begin
            in_fill_s = 1'b1;
        end else begin
            in_pend_s = 1'b1;
        end
        if (beat_cnt_q == BCNT_W'(BEATS - 1)) begin
            last_slot_s = 1'b1;
        end else begin
            last_slot_s = 1'b0;
        end
        // The write strobe is a pure function of state and full, so the
        // request drops in the same cycle the FIFO asserts full.
        if (in_pend_s && !inbuf_full) begin
            wr_fire_s = 1'b1;
        end else begin
            wr_fire_s = 1'b0;
        end
    end

    assign host_in_rdy   = in_fill_s;
    assign inbuf_wr_req  = wr_fire_s;
    assign inbuf_wr_data = line_q;
    assign pkr_busy      = in_pend_s | (beat_cnt_q != {BCNT_W{1'b0}});
    assign pkr_lines_cnt = lines_cnt_q;

    // Packer FSM: slot fill, line hand-off and lines-written counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            beat_cnt_q  <= {BCNT_W{1'b0}};
            line_q      <= {INBUF_DATA_W{1'b0}};
            lines_cnt_q <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (host_in_val) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_cnt_q == BCNT_W'(b)) begin
                                line_q[b*HOST_DATA_W +: HOST_DATA_W] <= host_in_data;
                            end
                        end
                        // beat_cnt is held in PEND so pkr_busy stays meaningful;
                        // it is cleared together with the line on the write.
                        if (last_slot_s || host_in_last) begin
                            state_q <= ST_PEND;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (!inbuf_full) begin
                        state_q     <= ST_FILL;
                        beat_cnt_q  <= {BCNT_W{1'b0}};
                        line_q      <= {INBUF_DATA_W{1'b0}};
                        lines_cnt_q <= lines_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_FILL;
                    beat_cnt_q <= {BCNT_W{1'b0}};
                    line_q     <= {INBUF_DATA_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inbuf_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_inbuf_wr_packer
//
// Self-checking bench for inbuf_wr_packer. A behavioural model keeps the
// accepted beats of the open line in a queue, a pending line plus a flag for a
// completed line waiting on the FIFO, and a lines-written count. Every cycle
// the DUT outputs are compared against the model at the falling edge.
// CNT_W is reduced so counter wrap-around is reachable quickly.
// -----------------------------------------------------------------------------
module tb_inbuf_wr_packer;

    localparam int HW    = 64;
    localparam int IW    = 512;
    localparam int CW    = 4;
    localparam int BEATS = IW / HW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_in_val;
    logic [HW-1:0] host_in_data;
    logic          host_in_last;
    logic          host_in_rdy;
    logic          inbuf_full;
    logic          inbuf_wr_req;
    logic [IW-1:0] inbuf_wr_data;
    logic          pkr_busy;
    logic [CW-1:0] pkr_lines_cnt;

    inbuf_wr_packer #(
        .HOST_DATA_W  (HW),
        .INBUF_DATA_W (IW),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_in_val   (host_in_val),
        .host_in_data  (host_in_data),
        .host_in_last  (host_in_last),
        .host_in_rdy   (host_in_rdy),
        .inbuf_full    (inbuf_full),
        .inbuf_wr_req  (inbuf_wr_req),
        .inbuf_wr_data (inbuf_wr_data),
        .pkr_busy      (pkr_busy),
        .pkr_lines_cnt (pkr_lines_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [HW-1:0] m_beats[$];
    logic          m_pend;
    logic [IW-1:0] m_pend_line;
    logic [CW-1:0] m_cnt;
    int            m_writes;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] build_line();
        logic [IW-1:0] l;
        l = '0;
        foreach (m_beats[i]) l[i*HW +: HW] = m_beats[i];
        return l;
    endfunction

    task automatic model_reset();
        m_beats.delete();
        m_pend      = 1'b0;
        m_pend_line = '0;
        m_cnt       = '0;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic step(input logic rst_v, input logic val_v, input logic last_v,
                        input logic full_v, input logic [HW-1:0] data_v);
        logic [IW-1:0] exp_data;
        rst_n        = rst_v;
        host_in_val  = val_v;
        host_in_last = last_v;
        inbuf_full   = full_v;
        host_in_data = data_v;
        @(negedge clk);
        exp_data = m_pend ? m_pend_line : build_line();
        chk("rdy",  IW'(host_in_rdy),   IW'(!m_pend));
        chk("req",  IW'(inbuf_wr_req),  IW'(m_pend && !full_v));
        chk("busy", IW'(pkr_busy),      IW'(m_pend || (m_beats.size() != 0)));
        chk("cnt",  IW'(pkr_lines_cnt), IW'(m_cnt));
        chk("data", inbuf_wr_data,      exp_data);
        @(posedge clk);
        if (!rst_v) begin
            model_reset();
        end else if (!m_pend) begin
            if (val_v) begin
                m_beats.push_back(data_v);
                if (last_v || m_beats.size() == BEATS) begin
                    m_pend_line = build_line();
                    m_pend      = 1'b1;
                end
            end
        end else if (!full_v) begin
            m_pend = 1'b0;
            m_beats.delete();
            m_cnt = m_cnt + 1'b1;
            m_writes++;
        end
        #1;
    endtask

    initial begin
        int w0;
        rst_n        = 1'b0;
        host_in_val  = 1'b0;
        host_in_last = 1'b0;
        inbuf_full   = 1'b0;
        host_in_data = '0;
        m_writes     = 0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // 8 beats 0..7 back-to-back, then idle
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b1, 1'b0, 1'b0, HW'(k));
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD);   // ignored while not ready
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t1_lines", IW'(pkr_lines_cnt), IW'(1));

        // short block of three beats, last on the third
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'hA);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'hB);
        step(1'b1, 1'b1, 1'b1, 1'b0, 64'hC);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // full line completes while FIFO is full, held 5 cycles
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b1, 1'b0, 1'b1, HW'(64'h100 + k));
        for (int k = 0; k < 5; k++)     step(1'b1, 1'b1, 1'b0, 1'b1, 64'hBAD);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // last on the final slot: exactly one write
        w0 = m_writes;
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b1, (k == BEATS-1), 1'b0, HW'(64'h200 + k));
        for (int k = 0; k < 3; k++)     step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t4_one_write", IW'(m_writes - w0), IW'(1));

        // reset mid-line, then a fresh line
        for (int k = 0; k < 4; k++)     step(1'b1, 1'b1, 1'b0, 1'b0, HW'(64'h300 + k));
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'h3FF);
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b1, 1'b0, 1'b0, HW'(64'h400 + k));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t5_lines", IW'(pkr_lines_cnt), IW'(1));

        // counter wrap: 2^CW lines of one beat each from reset
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < (1 << CW); k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, HW'(64'h500 + k));
            step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
        chk("t6_wrap", IW'(pkr_lines_cnt), IW'(0));

        // randomized traffic with back-pressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0),
                 {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
